// File: rtl/adc_sample_collector.sv
// Averages 2^AVG_LOG2 ADC strobes taken after each switching blank; result lands 1 f_clk after the last strobe.
// Never stalls: a result that is not consumed before the next one loads is overwritten and flagged as overrun.
module adc_sample_collector #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 5
) (
  input  logic              f_clk,
  input  logic              f_rst_n,
  input  logic              f_adc_clock,
  input  logic              f_sw,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_otr,
  input  logic              sample_ready,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              sample_otr,
  output logic              short_err,
  output logic              overrun
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(1) << AVG_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_ACQ,
    ST_HOLD
  } state_t;

  state_t            r_state;
  logic              r_f_sw_d;
  logic              r_sw_armed;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_otr_acc;
  logic [DATA_W-1:0] r_sample_out;
  logic              r_sample_valid;
  logic              r_sample_otr;
  logic              r_short_err;
  logic              r_overrun;

  logic              w_sw_rise;
  logic              w_done;
  logic              w_strobe;

  // r_sw_armed keeps a switch already high at reset release from looking like a fresh edge
  assign w_sw_rise = f_sw & ~r_f_sw_d & r_sw_armed;
  assign w_done    = (r_state == ST_ACQ) && (r_cnt == N_SAMPLES);
  assign w_strobe  = (r_state == ST_ACQ) && f_adc_clock;

  always_ff @(posedge f_clk) begin
    if (!f_rst_n) begin
      r_state        <= ST_IDLE;
      r_f_sw_d       <= 1'b0;
      r_sw_armed     <= 1'b0;
      r_acc          <= '0;
      r_cnt          <= '0;
      r_otr_acc      <= 1'b0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_sample_otr   <= 1'b0;
      r_short_err    <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_f_sw_d    <= f_sw;
      r_sw_armed  <= 1'b1;
      r_short_err <= 1'b0;

      // A load in the same cycle as a handshake keeps valid high without counting as overrun
      if (w_done) begin
        r_sample_out   <= DATA_W'(r_acc >> AVG_LOG2);
        r_sample_otr   <= r_otr_acc;
        r_sample_valid <= 1'b1;
        if (r_sample_valid && !sample_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (r_sample_valid && sample_ready) begin
        r_sample_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_sw_rise) begin
            r_state <= ST_BLANK;
          end
        end
        ST_BLANK: begin
          if (!f_sw) begin
            r_state <= ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (w_done) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_otr_acc <= 1'b0;
            r_state   <= w_sw_rise ? ST_BLANK : ST_HOLD;
          end else if (w_sw_rise) begin
            // Period ended early: drop the partial sum, keep the last result
            r_short_err <= 1'b1;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_otr_acc   <= 1'b0;
            r_state     <= ST_BLANK;
          end else if (w_strobe) begin
            r_acc     <= r_acc + ACC_W'(adc_data);
            r_cnt     <= r_cnt + CNT_W'(1);
            r_otr_acc <= r_otr_acc | adc_otr;
          end
        end
        ST_HOLD: begin
          if (w_sw_rise) begin
            r_state <= ST_BLANK;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sample_out   = r_sample_out;
  assign sample_valid = r_sample_valid;
  assign sample_otr   = r_sample_otr;
  assign short_err    = r_short_err;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_adc_sample_collector.sv
// Bench for adc_sample_collector: directed period sequence with random data against a period-level reference model.
module tb_adc_sample_collector;

  localparam int DATA_W   = 12;
  localparam int AVG_LOG2 = 5;
  localparam int N        = 1 << AVG_LOG2;

  localparam int M_RAND   = 0;
  localparam int M_C800   = 1;
  localparam int M_RAMP   = 2;
  localparam int M_RAMPO  = 3;
  localparam int M_C100   = 4;
  localparam int M_C200   = 5;
  localparam int M_COINC  = 6;

  localparam int R_ONE    = 0;
  localparam int R_ZERO   = 1;
  localparam int R_RAND   = 2;

  logic              f_clk = 1'b0;
  logic              f_rst_n;
  logic              f_adc_clock;
  logic              f_sw;
  logic [DATA_W-1:0] adc_data;
  logic              adc_otr;
  logic              sample_ready;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              sample_otr;
  logic              short_err;
  logic              overrun;

  int errors = 0;
  int checks = 0;

  logic              exp_valid;
  logic [DATA_W-1:0] exp_out;
  logic              exp_otr;
  logic              exp_short;
  logic              exp_ovr;
  bit                prev_collecting;

  adc_sample_collector #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) dut (
    .f_clk        (f_clk),
    .f_rst_n      (f_rst_n),
    .f_adc_clock  (f_adc_clock),
    .f_sw         (f_sw),
    .adc_data     (adc_data),
    .adc_otr      (adc_otr),
    .sample_ready (sample_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_otr   (sample_otr),
    .short_err    (short_err),
    .overrun      (overrun)
  );

  always #5 f_clk = ~f_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    check(tag, {48'd0, sample_valid, sample_out, sample_otr, short_err, overrun},
               {48'd0, exp_valid, exp_out, exp_otr, exp_short, exp_ovr});
  endtask

  // One switching period: f_sw high for high_len cycles, strobe every 4 cycles at phase.
  // The model picks the first N strobes strictly after the cycle f_sw is first seen low.
  task automatic run_period(input string tag, input int len, input int high_len, input int phase,
                            input int mode, input int rdy_mode, input int rst_at);
    logic [DATA_W-1:0] d [512];
    bit                stb [512];
    bit                o [512];
    int                nacc;
    int                sum;
    bit                otr_or;
    int                load_idx;
    nacc = 0; sum = 0; otr_or = 1'b0; load_idx = -1;
    for (int i = 0; i < len; i++) begin
      stb[i] = ((i % 4) == phase);
      d[i]   = DATA_W'($urandom);
      o[i]   = ($urandom_range(0, 7) == 0);
      if (mode == M_COINC) begin
        d[i] = (i == 0) ? 12'hFFF : 12'h000;
        o[i] = 1'b0;
      end
      if (stb[i] && i > high_len && nacc < N && (rst_at < 0 || i < rst_at)) begin
        case (mode)
          M_C800:  begin d[i] = 12'h800; o[i] = 1'b0; end
          M_RAMP:  begin d[i] = DATA_W'(nacc); o[i] = 1'b0; end
          M_RAMPO: begin d[i] = DATA_W'(nacc); o[i] = (nacc == 7); end
          M_C100:  begin d[i] = 12'h100; o[i] = 1'b0; end
          M_C200:  begin d[i] = 12'h200; o[i] = 1'b0; end
          default: ;
        endcase
        sum    += int'(d[i]);
        otr_or |= o[i];
        nacc++;
        if (nacc == N) load_idx = i + 1;
      end
    end
    for (int i = 0; i < len; i++) begin
      @(negedge f_clk);
      f_sw        = (i < high_len);
      f_adc_clock = stb[i];
      adc_data    = d[i];
      adc_otr     = o[i];
      f_rst_n     = (i != rst_at);
      case (rdy_mode)
        R_ONE:   sample_ready = 1'b1;
        R_ZERO:  sample_ready = 1'b0;
        default: sample_ready = 1'($urandom_range(0, 1));
      endcase
      if (i == rst_at) begin
        exp_valid = 1'b0; exp_out = '0; exp_otr = 1'b0; exp_short = 1'b0; exp_ovr = 1'b0;
        prev_collecting = 1'b0;
      end else begin
        exp_short = (i == 0) && prev_collecting;
        if (i == load_idx) begin
          if (exp_valid && !sample_ready) exp_ovr = 1'b1;
          exp_valid = 1'b1;
          exp_out   = DATA_W'(sum >> AVG_LOG2);
          exp_otr   = otr_or;
        end else if (exp_valid && sample_ready) begin
          exp_valid = 1'b0;
        end
      end
      @(posedge f_clk);
      #1;
      check_outputs(tag);
    end
    if (rst_at < 0) prev_collecting = (nacc > 0 || len > high_len + 1) && (nacc < N);
    f_rst_n = 1'b1;
  endtask

  initial begin
    f_rst_n = 1'b0; f_sw = 1'b0; f_adc_clock = 1'b0; adc_data = '0; adc_otr = 1'b0; sample_ready = 1'b1;
    exp_valid = 1'b0; exp_out = '0; exp_otr = 1'b0; exp_short = 1'b0; exp_ovr = 1'b0;
    prev_collecting = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge f_clk);
      f_rst_n     = (i >= 2);
      f_adc_clock = (i == 3);
      adc_data    = 12'hABC;
      @(posedge f_clk);
      #1;
      check_outputs("reset");
    end

    run_period("const800", 500, 50, 1, M_C800, R_ONE, -1);
    check("const800_out", 64'(sample_out), 64'h800);
    run_period("ramp", 500, 50, 2, M_RAMP, R_ONE, -1);
    check("ramp_out", 64'(sample_out), 64'h00F);
    check("ramp_otr", 64'(sample_otr), 64'h0);
    run_period("ramp_otr", 500, 50, 3, M_RAMPO, R_ONE, -1);
    check("ramp_otr_out", 64'(sample_out), 64'h00F);
    check("ramp_otr_flag", 64'(sample_otr), 64'h1);

    for (int p = 0; p < 3; p++) run_period("rand_rdy", 500, 40 + 10 * p, p, M_RAND, R_RAND, -1);

    for (int p = 0; p < 3; p++) run_period("short", 100, 10, 2, M_RAND, R_ONE, -1);
    run_period("after_short", 500, 50, 0, M_RAND, R_ONE, -1);

    run_period("ovr_100", 500, 50, 1, M_C100, R_ZERO, -1);
    run_period("ovr_200", 500, 50, 1, M_C200, R_ZERO, -1);
    check("ovr_out", 64'(sample_out), 64'h200);
    check("ovr_valid", 64'(sample_valid), 64'h1);
    check("ovr_flag", 64'(overrun), 64'h1);
    run_period("drain", 500, 50, 2, M_RAND, R_ONE, -1);

    // Strobes sampled at cycles 53,57,...: the 16th lands at 113, reset follows at 114
    run_period("rst_acq", 500, 50, 1, M_RAND, R_ONE, 114);
    run_period("post_rst", 500, 50, 1, M_RAND, R_ONE, -1);
    run_period("rst_high", 500, 50, 3, M_RAND, R_ONE, 5);
    run_period("post_rst_high", 500, 50, 3, M_RAND, R_RAND, -1);

    run_period("pre_coinc", 100, 10, 0, M_RAND, R_ONE, -1);
    run_period("coinc", 500, 50, 0, M_COINC, R_ONE, -1);
    check("coinc_out", 64'(sample_out), 64'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_sample_collector.md
ADC_SAMPLE_COLLECTOR -- requirements
Module: adc_sample_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning ADC sample width in bits.
REQ-002 SHALL have parameter AVG_LOG2, default 5, meaning log2 of samples averaged per switching period (N = 2^AVG_LOG2).
REQ-003 SHALL have port f_clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port f_rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port f_adc_clock  input  1  one-f_clk-wide sample strobe from the clock generator.
REQ-006 SHALL have port f_sw  input  1  switching-period marker; its rising edge starts a period and it is high during switching.
REQ-007 SHALL have port adc_data  input  DATA_W  unsigned ADC conversion result, valid whenever f_adc_clock is high.
REQ-008 SHALL have port adc_otr  input  1  ADC out-of-range flag, qualified by f_adc_clock.
REQ-009 SHALL have port sample_ready  input  1  consumer (PID) accepts sample_out.
REQ-010 SHALL have port sample_out  output  DATA_W  averaged sample for the current period.
REQ-011 SHALL have port sample_valid  output  1  sample_out holds an unconsumed result.
REQ-012 SHALL have port sample_otr  output  1  at least one averaged sample had adc_otr high.
REQ-013 SHALL have port short_err  output  1  one-cycle pulse: period ended before N samples collected.
REQ-014 SHALL have port overrun  output  1  sticky: a result was overwritten unconsumed.

Function
REQ-015 SHALL detect f_sw rising edge from a registered copy of f_sw (edge = f_sw & ~f_sw_d).
REQ-016 SHALL implement states IDLE, BLANK, ACQ, HOLD.
REQ-017 IDLE -> BLANK on f_sw rising edge; no other exit.
REQ-018 BLANK: all strobes ignored while f_sw high; BLANK -> ACQ in the cycle after f_sw is sampled low.
REQ-019 ACQ: on each f_adc_clock, acc += adc_data (zero-extended), cnt += 1, otr_acc |= adc_otr.
REQ-020 Accumulator SHALL be DATA_W+AVG_LOG2 bits, never overflow, counter AVG_LOG2+1 bits.
REQ-021 When cnt reaches N, next cycle: sample_out <= acc >> AVG_LOG2 (truncating), sample_otr <= otr_acc, sample_valid <= 1, state -> HOLD, acc/cnt/otr_acc cleared.
REQ-022 Result latency SHALL be exactly 1 f_clk after the N-th accepted strobe.
REQ-023 HOLD: strobes ignored; HOLD -> BLANK on f_sw rising edge.
REQ-024 f_sw rising edge while in ACQ (cnt < N): short_err pulses 1 cycle, partial acc discarded, sample_out unchanged, state -> BLANK.
REQ-025 f_sw rising edge coincident with f_adc_clock: strobe SHALL be ignored (blanking wins).
REQ-026 sample_valid SHALL clear on the cycle after sample_valid & sample_ready, unless a new result loads in that same cycle, in which case it stays 1 with no overrun.
REQ-027 New result loaded while sample_valid=1 and sample_ready=0: sample_out overwritten, overrun set, stays set until reset.
REQ-028 sample_out and sample_otr SHALL be stable while sample_valid=1 and no new result loads.
REQ-029 At system rates (strobe every 4 f_clk, period 500 f_clk) default N=32 SHALL complete within one period.

Reset
REQ-030 On f_rst_n low at a clock edge: state IDLE, acc=0, cnt=0, f_sw_d=0, sample_out=0, sample_valid=0, sample_otr=0, short_err=0, overrun=0.
REQ-031 Reset mid-ACQ or mid-HOLD SHALL discard partial data; first result after release requires a fresh f_sw rising edge.
REQ-032 f_sw high at reset release SHALL NOT produce an edge (f_sw_d reset to 0 then captures; edge only on a later low-to-high).

Verification
REQ-033 Constant adc_data=0x800, sample_ready=1, standard period -> sample_out=0x800, sample_valid 1 cycle, 1 cycle after 32nd post-blank strobe.
REQ-034 Ramp adc_data=0..31 on successive strobes -> sample_out=0x00F (496>>5), sample_otr=0; repeat with adc_otr high on strobe 7 -> sample_otr=1.
REQ-035 f_sw period shortened to 100 f_clk (~22 strobes) -> short_err pulse at each edge, sample_valid never asserted.
REQ-036 sample_ready=0 across two periods with data 0x100 then 0x200 -> sample_out=0x200, sample_valid=1, overrun=1.
REQ-037 f_rst_n low for 1 cycle after 16 accepted strobes -> all outputs 0; next complete period yields correct average of only post-reset samples.
REQ-038 f_adc_clock coincident with f_sw rising edge, data 0xFFF on that strobe only, else 0 -> sample_out=0x000.
